phy_mdio_master: RTL and testbench

Parametrised IEEE 802.3 Clause-22 MDIO management master for the RGMII PHY. It generates MDC and the PHY hardware reset. It runs complete read and write frames to any PHY address and register address, requested through a valid/ready command port, and returns read data on a one-cycle response strobe. It sits between the management/config logic and the board-level MDIO IOBUF, which is instantiated outside this block.

---
 rtl/phy_mdio_master.sv | 189 ++++++++++++++++++
 tb/tb_phy_mdio_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mdio_master.sv
// phy_mdio_master: Clause-22 MDIO master with MDC divider, PHY reset sequencer and read/write frame engine
module phy_mdio_master #(
    parameter int MDC_HALF = 25,
    parameter int PRE_LEN  = 32,
    parameter int RST_HOLD = 1250
) (
    input  logic        rgmii_clk_in,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    output logic        phy_rstn
);
    localparam int DW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
    localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(MDC_HALF - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_HOLD - 1);
    localparam logic [4:0]    PRE_LAST = 5'(PRE_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_q;
    logic [RW-1:0] rst_cnt;
    logic [1:0]    sync_q;
    logic          fall_stb, rise_stb, hs;
    logic [4:0]    cnt, cnt_n;
    logic [31:0]   sh, sh_n;
    logic          wr_q, wr_n;
    logic [15:0]   rd_q, rd_n;
    logic          err_q, err_n;
    logic          mdio_o_n, mdio_t_n, rsp_valid_n, rsp_error_n;
    logic [15:0]   rsp_rdata_n;

    assign fall_stb  = (div_q == DIV_LAST) && mdc;
    assign rise_stb  = (div_q == DIV_LAST) && !mdc;
    assign cmd_ready = (state == S_IDLE) && phy_rstn;
    assign busy      = state != S_IDLE;
    assign hs        = cmd_valid && cmd_ready;

    // Free-running MDC divider; mdc toggles each time the divider wraps
    always_ff @(posedge rgmii_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            div_q <= '0;
            mdc   <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            mdc   <= ~mdc;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Hold the PHY in reset for RST_HOLD clocks after sys_rst releases
    always_ff @(posedge rgmii_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            rst_cnt  <= '0;
            phy_rstn <= 1'b0;
        end else if (!phy_rstn) begin
            if (rst_cnt == RST_LAST) phy_rstn <= 1'b1;
            else rst_cnt <= rst_cnt + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous MDIO pad input
    always_ff @(posedge rgmii_clk_in or posedge sys_rst) begin
        if (sys_rst) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], mdio_i};
    end

    // Frame engine registers: state, field counter, shifter, capture and response
    always_ff @(posedge rgmii_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sh        <= '1;
            wr_q      <= 1'b0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            wr_q      <= wr_n;
            rd_q      <= rd_n;
            err_q     <= err_n;
            mdio_o    <= mdio_o_n;
            mdio_t    <= mdio_t_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_error <= rsp_error_n;
        end
    end

    // Next-state logic; the shifter holds ST/OP/PHYAD/REGAD/TA/DATA and drives bit 30 on each fall_stb
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sh_n        = sh;
        wr_n        = wr_q;
        rd_n        = rd_q;
        err_n       = err_q;
        mdio_o_n    = mdio_o;
        mdio_t_n    = mdio_t;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_error_n = rsp_error;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_n = S_WAIT;
                    wr_n    = cmd_write;
                    sh_n    = cmd_write ? {4'b0101, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata}
                                        : {4'b0110, cmd_phy_addr, cmd_reg_addr, 18'h3FFFF};
                end
            end
            S_WAIT: begin
                if (fall_stb) begin
                    state_n  = S_PRE;
                    cnt_n    = '0;
                    mdio_o_n = 1'b1;
                    mdio_t_n = 1'b0;
                end
            end
            S_PRE: begin
                if (fall_stb) begin
                    state_n  = (cnt == PRE_LAST) ? S_HDR : S_PRE;
                    cnt_n    = (cnt == PRE_LAST) ? 5'd0 : cnt + 5'd1;
                    mdio_o_n = (cnt == PRE_LAST) ? sh[31] : 1'b1;
                end
            end
            S_HDR: begin
                if (fall_stb) begin
                    sh_n     = sh << 1;
                    mdio_o_n = sh[30];
                    state_n  = (cnt == 5'd13) ? S_TA : S_HDR;
                    cnt_n    = (cnt == 5'd13) ? 5'd0 : cnt + 5'd1;
                    mdio_t_n = (cnt == 5'd13) ? ~wr_q : mdio_t;
                end
            end
            S_TA: begin
                if (rise_stb && cnt == 5'd1) err_n = sync_q[1];
                if (fall_stb) begin
                    sh_n     = sh << 1;
                    mdio_o_n = sh[30];
                    state_n  = (cnt == 5'd1) ? S_DATA : S_TA;
                    cnt_n    = (cnt == 5'd1) ? 5'd0 : cnt + 5'd1;
                end
            end
            S_DATA: begin
                if (rise_stb) rd_n = {rd_q[14:0], sync_q[1]};
                if (fall_stb) begin
                    sh_n     = sh << 1;
                    state_n  = (cnt == 5'd15) ? S_DONE : S_DATA;
                    cnt_n    = (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
                    mdio_o_n = (cnt == 5'd15) ? 1'b1 : sh[30];
                    mdio_t_n = (cnt == 5'd15) ? 1'b1 : mdio_t;
                end
            end
            S_DONE: begin
                if (fall_stb) begin
                    state_n     = S_IDLE;
                    mdio_o_n    = 1'b1;
                    mdio_t_n    = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = wr_q ? 16'h0000 : rd_q;
                    rsp_error_n = wr_q ? 1'b0 : err_q;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_phy_mdio_master.sv
// tb_phy_mdio_master: directed bench with frame monitor and a Clause-22 PHY responder
module tb_phy_mdio_master;
    localparam int RST_HOLD = 1250;

    logic        clk;
    logic        sys_rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_phy_addr, cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_error, busy, mdc, mdio_o, mdio_t, mdio_i, phy_rstn;
    logic [15:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic        mdc_d = 1'b0;
    logic        in_frame = 1'b0;
    int          nb = 0;
    int          frames = 0;
    int          idle_falls = 0;
    int          last_gap = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_t = '0;
    logic        phy_on = 1'b0;
    logic [15:0] phy_data = '0;

    phy_mdio_master #(.MDC_HALF(25), .PRE_LEN(32), .RST_HOLD(RST_HOLD)) dut (
        .rgmii_clk_in(clk),
        .sys_rst(sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr),
        .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .busy(busy),
        .mdc(mdc),
        .mdio_o(mdio_o),
        .mdio_t(mdio_t),
        .mdio_i(mdio_i),
        .phy_rstn(phy_rstn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor records every frame bit at MDC falls; PHY model drives mdio_i after MDC rises
    always @(negedge clk) begin
        if (sys_rst) begin
            in_frame <= 1'b0;
            nb       <= 0;
            mdio_i   <= 1'b1;
        end else begin
            if (mdc && !mdc_d) begin
                if (phy_on && in_frame && nb == 47) mdio_i <= 1'b0;
                else if (phy_on && in_frame && nb >= 48 && nb <= 63) mdio_i <= phy_data[4'(63 - nb)];
                else mdio_i <= 1'b1;
            end
            if (!mdc && mdc_d) begin
                if (!in_frame && !mdio_t) begin
                    in_frame <= 1'b1;
                    nb       <= 1;
                    last_gap <= idle_falls;
                    cap_o    <= {cap_o[62:0], mdio_o};
                    cap_t    <= {cap_t[62:0], mdio_t};
                end else if (in_frame) begin
                    cap_o <= {cap_o[62:0], mdio_o};
                    cap_t <= {cap_t[62:0], mdio_t};
                    nb    <= nb + 1;
                    if (nb == 63) begin
                        in_frame   <= 1'b0;
                        frames     <= frames + 1;
                        idle_falls <= 0;
                    end
                end else begin
                    idle_falls <= idle_falls + 1;
                end
            end
        end
        mdc_d <= mdc;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdc_period(output int p);
        int  c;
        bit  prev, seen;
        p = -1; c = 0; seen = 0; prev = mdc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mdc && !prev) begin
                if (seen) begin
                    p = c;
                    break;
                end
                seen = 1;
                c = 0;
            end
            c++;
            prev = mdc;
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                           output logic [15:0] rd, output logic er);
        bit ok;
        int lat, fr0;
        fr0 = frames;
        @(negedge clk);
        cmd_write = wr; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("accept", ok, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_low_when_busy", cmd_ready, 0);
        lat = -1;
        for (int i = 0; i <= 4000; i++) begin
            if (rsp_valid) begin lat = i; break; end
            @(negedge clk);
        end
        chk("latency_bound", lat >= 0 && lat <= 3300, 1);
        rd = rsp_rdata;
        er = rsp_error;
        chk("frame_count", frames - fr0, 1);
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("bus_released", mdio_t, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          p, fr0;
        bit          ok, bad;
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
        phy_on = 1'b0; phy_data = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mdc", mdc, 0);
        chk("rst_mdio_o", mdio_o, 1);
        chk("rst_mdio_t", mdio_t, 1);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phy_rstn", phy_rstn, 0);
        chk("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (RST_HOLD - 1) @(posedge clk);
        #1;
        chk("phy_rstn_hold", phy_rstn, 0);
        chk("ready_in_hold", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("phy_rstn_release", phy_rstn, 1);
        chk("ready_after_hold", cmd_ready, 1);
        mdc_period(p);
        chk("mdc_period", p, 50);

        run_cmd(1'b1, 5'h01, 5'h00, 16'h1140, rd, er);
        chk("wr_frame", cap_o, {32'hFFFF_FFFF, 4'b0101, 5'h01, 5'h00, 2'b10, 16'h1140});
        chk("wr_frame_hex", cap_o, 64'hFFFF_FFFF_5082_1140);
        chk("wr_mdio_t", cap_t, 64'h0);
        chk("wr_rdata", rd, 16'h0000);
        chk("wr_error", er, 0);

        phy_on = 1'b1; phy_data = 16'h0141;
        run_cmd(1'b0, 5'h01, 5'h02, 16'h0000, rd, er);
        chk("rd_header", cap_o[63:18], {32'hFFFF_FFFF, 14'b01_10_00001_00010});
        chk("rd_mdio_t", cap_t, 64'h0000_0000_0003_FFFF);
        chk("rd_rdata", rd, 16'h0141);
        chk("rd_error", er, 0);

        phy_on = 1'b0;
        run_cmd(1'b0, 5'h05, 5'h03, 16'h0000, rd, er);
        chk("nophy_header", cap_o[63:18], {32'hFFFF_FFFF, 14'b01_10_00101_00011});
        chk("nophy_rdata", rd, 16'hFFFF);
        chk("nophy_error", er, 1);

        fr0 = frames;
        @(negedge clk);
        cmd_write = 1'b1; cmd_phy_addr = 5'h02; cmd_reg_addr = 5'h04; cmd_wdata = 16'hA5A5; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("q_accept_a", ok, 1);
        @(negedge clk);
        cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h05; cmd_wdata = 16'h5A5A;
        ok = 0; bad = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            if (cmd_ready) bad = 1;
            @(negedge clk);
        end
        chk("q_rsp_a", ok, 1);
        chk("q_no_early_accept", bad, 0);
        chk("q_frame_a", cap_o, {32'hFFFF_FFFF, 4'b0101, 5'h02, 5'h04, 2'b10, 16'hA5A5});
        chk("q_wr_clears_error", rsp_error, 0);
        chk("q_wr_rdata", rsp_rdata, 16'h0000);
        ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("q_busy_fall", ok, 1);
        chk("q_ready_idle", cmd_ready, 1);
        @(negedge clk);
        chk("q_accept_b", busy, 1);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("q_rsp_b", ok, 1);
        chk("q_frame_b", cap_o, {32'hFFFF_FFFF, 4'b0101, 5'h03, 5'h05, 2'b10, 16'h5A5A});
        chk("q_gap", last_gap >= 1, 1);
        chk("q_frames", frames - fr0, 2);

        phy_on = 1'b1; phy_data = 16'hC3C3;
        @(negedge clk);
        cmd_write = 1'b0; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h02; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("abort_accept", ok, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (in_frame && nb >= 52) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("abort_in_data", ok, 1);
        sys_rst = 1'b1;
        #1;
        chk("abort_mdio_t", mdio_t, 1);
        chk("abort_mdio_o", mdio_o, 1);
        chk("abort_mdc", mdc, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 0);
        chk("abort_phy_rstn", phy_rstn, 0);
        repeat (5) @(negedge clk);
        sys_rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 1400; i++) begin
            if (phy_rstn) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("recover_phy_rstn", ok, 1);
        phy_on = 1'b0;
        run_cmd(1'b1, 5'h1F, 5'h1F, 16'hBEEF, rd, er);
        chk("recover_frame", cap_o, {32'hFFFF_FFFF, 4'b0101, 5'h1F, 5'h1F, 2'b10, 16'hBEEF});
        chk("recover_mdio_t", cap_t, 64'h0);
        chk("recover_rdata", rd, 16'h0000);
        chk("recover_error", er, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
